// File: rtl/fetch_unit_if.sv
// Shared 4-bit bus between the fetch sequencer and the ROM chips.
interface fetch_unit_if;
    localparam int unsigned NIB_W = 4;

    logic [NIB_W-1:0] data_i;
    logic [NIB_W-1:0] data_o;
    logic             data_en;
    logic             sync;
    logic             cmd;

    // Fetch sequencer side: drives address nibbles and the timing strobes.
    modport master (
        input  data_i,
        output data_o,
        output data_en,
        output sync,
        output cmd
    );

    // ROM side: watches the strobes and returns instruction nibbles.
    modport slave (
        output data_i,
        input  data_o,
        input  data_en,
        input  sync,
        input  cmd
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: 8-subcycle bus cycle, 12-bit PC with jump load.
// Optional feature macro: FETCH_STALL_EN adds a stall port that holds the PC.
module fetch_unit #(
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic         clock,
    input  logic         reset,
    fetch_unit_if.master bus,
    input  logic         jump_valid,
    input  logic [11:0]  jump_addr,
    output logic [7:0]   inst_o,
    output logic         inst_valid,
    output logic [11:0]  pc_o
`ifdef FETCH_STALL_EN
    ,
    input  logic         stall
`endif
);
    localparam int unsigned PC_W   = 12;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned INST_W = 8;

    typedef enum logic [2:0] {
        A1 = 3'd0,
        A2 = 3'd1,
        A3 = 3'd2,
        M1 = 3'd3,
        M2 = 3'd4,
        X1 = 3'd5,
        X2 = 3'd6,
        X3 = 3'd7
    } cycle_t;

    cycle_t            cycle;
    cycle_t            cycle_next;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc_next;
    logic [NIB_W-1:0]  inst_hi;
    logic              stall_w;

    logic [NIB_W-1:0]  data_o_c;
    logic              data_en_c;
    logic              sync_c;
    logic              cmd_c;

`ifdef FETCH_STALL_EN
    assign stall_w = stall;
`else
    assign stall_w = 1'b0;
`endif

    // Subcycle counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle <= A1;
        end else begin
            cycle <= cycle_next;
        end
    end

    // Next subcycle and bus drive decode; all strobes idle while reset is held.
    always_comb begin
        cycle_next = A1;
        data_o_c   = '0;
        data_en_c  = 1'b0;
        sync_c     = 1'b0;
        cmd_c      = 1'b1;
        case (cycle)
            A1: begin
                cycle_next = A2;
                data_o_c   = pc[3:0];
                data_en_c  = 1'b1;
            end
            A2: begin
                cycle_next = A3;
                data_o_c   = pc[7:4];
                data_en_c  = 1'b1;
            end
            A3: begin
                cycle_next = M1;
                data_o_c   = pc[11:8];
                data_en_c  = 1'b1;
                cmd_c      = 1'b0;
            end
            M1: cycle_next = M2;
            M2: cycle_next = X1;
            X1: cycle_next = X2;
            X2: cycle_next = X3;
            X3: begin
                cycle_next = A1;
                sync_c     = 1'b1;
            end
            default: cycle_next = A1;
        endcase
        if (reset) begin
            data_o_c  = '0;
            data_en_c = 1'b0;
            sync_c    = 1'b0;
            cmd_c     = 1'b1;
        end
    end

    // PC update choice for the end of the instruction cycle: stall, jump, then increment.
    always_comb begin
        pc_next = PC_W'(pc + PC_W'(1));
        if (stall_w) begin
            pc_next = pc;
        end else if (jump_valid) begin
            pc_next = jump_addr;
        end
    end

    // PC, instruction capture and valid strobe; high nibble is shadowed so inst_o changes atomically.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc         <= RESET_PC;
            inst_hi    <= '0;
            inst_o     <= '0;
            inst_valid <= 1'b0;
        end else begin
            inst_valid <= (cycle == M2);
            if (cycle == M1) begin
                inst_hi <= bus.data_i;
            end
            if (cycle == M2) begin
                inst_o <= INST_W'({inst_hi, bus.data_i});
            end
            if (cycle == X3) begin
                pc <= pc_next;
            end
        end
    end

    assign pc_o        = pc;
    assign bus.data_o  = data_o_c;
    assign bus.data_en = data_en_c;
    assign bus.sync    = sync_c;
    assign bus.cmd     = cmd_c;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomized bench for fetch_unit with a behavioural ROM and PC model.
module tb_fetch_unit;
    localparam logic [11:0] TB_RESET_PC = 12'h000;

    logic        clock;
    logic        reset;
    logic        jump_valid;
    logic [11:0] jump_addr;
    logic [7:0]  inst_o;
    logic        inst_valid;
    logic [11:0] pc_o;
`ifdef FETCH_STALL_EN
    logic        stall;
`endif

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(TB_RESET_PC)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .jump_valid (jump_valid),
        .jump_addr  (jump_addr),
        .inst_o     (inst_o),
        .inst_valid (inst_valid),
        .pc_o       (pc_o)
`ifdef FETCH_STALL_EN
        ,
        .stall      (stall)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  rom [4096];
    int          mpc;       // model program counter
    logic [7:0]  exp_inst;  // model of last delivered instruction

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state();
        #1;
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_pc", 32'(pc_o), 32'(TB_RESET_PC));
        chk("rst_inst", 32'(inst_o), 32'h00);
        chk("rst_data_en", 32'(bus.data_en), 32'd0);
        chk("rst_data_o", 32'(bus.data_o), 32'd0);
        chk("rst_sync", 32'(bus.sync), 32'd0);
        chk("rst_cmd", 32'(bus.cmd), 32'd1);
    endtask

    // One instruction cycle starting at subcycle 0; ROM answers from the address it saw on the bus.
    task automatic do_cycle(input bit jv, input logic [11:0] ja, input bit st, input int rst_sub);
        logic [11:0] cap;
        logic [3:0]  exp_nib;
        bit          aborted;
        cap = '0;
        aborted = 1'b0;
        for (int s = 0; s < 8; s++) begin
            #1;
            if (s == 5) exp_inst = rom[mpc];
            exp_nib = (s < 3) ? 4'((mpc >> (4 * s)) & 15) : 4'd0;
            chk("data_en", 32'(bus.data_en), 32'(s < 3));
            chk("data_o", 32'(bus.data_o), 32'(exp_nib));
            chk("cmd", 32'(bus.cmd), 32'(s != 2));
            chk("sync", 32'(bus.sync), 32'(s == 7));
            chk("inst_valid", 32'(inst_valid), 32'(s == 5));
            chk("inst_o", 32'(inst_o), 32'(exp_inst));
            chk("pc_o", 32'(pc_o), 32'(mpc));
            if (s < 3) cap[4*s +: 4] = bus.data_o;
            if (s == 3)      bus.data_i = rom[cap][7:4];
            else if (s == 4) bus.data_i = rom[cap][3:0];
            else             bus.data_i = 4'($urandom);
            jump_valid = (s == 7) ? jv : 1'($urandom);
            jump_addr  = (s == 7) ? ja : 12'($urandom);
`ifdef FETCH_STALL_EN
            stall = (s == 7) ? st : 1'($urandom);
`endif
            if (s == rst_sub) begin
                reset = 1'b1;
                aborted = 1'b1;
            end
            @(negedge clock);
            if (aborted) break;
        end
        if (!aborted) begin
`ifdef FETCH_STALL_EN
            if (st) mpc = mpc;
            else if (jv) mpc = int'(ja);
            else mpc = (mpc + 1) % 4096;
`else
            if (jv) mpc = int'(ja);
            else mpc = (mpc + 1) % 4096;
`endif
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
        rom[0] = 8'hA5;
        reset = 1'b1;
        jump_valid = 1'b0;
        jump_addr = '0;
        bus.data_i = '0;
`ifdef FETCH_STALL_EN
        stall = 1'b0;
`endif
        mpc = int'(TB_RESET_PC);
        exp_inst = 8'h00;
        repeat (3) @(negedge clock);
        chk_reset_state();
        @(negedge clock);
        reset = 1'b0;

        // First fetch from address 0, then eight consecutive increments.
        do_cycle(1'b0, 12'h000, 1'b0, -1);
        for (int i = 0; i < 8; i++) do_cycle(1'b0, 12'h000, 1'b0, -1);

        // Jump to 12'h3C7, fetch it, then jump to the top and wrap.
        do_cycle(1'b1, 12'h3C7, 1'b0, -1);
        do_cycle(1'b1, 12'hFFF, 1'b0, -1);
        do_cycle(1'b0, 12'h000, 1'b0, -1);
        do_cycle(1'b0, 12'h000, 1'b0, -1);

`ifdef FETCH_STALL_EN
        // Stall at 12'h010 refetches it, and a stall beats a simultaneous jump.
        do_cycle(1'b1, 12'h010, 1'b0, -1);
        do_cycle(1'b0, 12'h000, 1'b1, -1);
        do_cycle(1'b1, 12'h5A5, 1'b1, -1);
        do_cycle(1'b0, 12'h000, 1'b0, -1);
        do_cycle(1'b0, 12'h000, 1'b0, -1);
`endif

        // Reset asserted in subcycle 3 aborts the fetch.
        do_cycle(1'b1, 12'h123, 1'b0, 3);
        repeat (3) begin
            chk_reset_state();
            @(negedge clock);
        end
        reset = 1'b0;
        mpc = int'(TB_RESET_PC);
        exp_inst = 8'h00;
        do_cycle(1'b0, 12'h000, 1'b0, -1);

        // Randomized jumps/stalls against the model.
        for (int i = 0; i < 24; i++) begin
            do_cycle(($urandom % 4) == 0, 12'($urandom), ($urandom % 5) == 0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
